// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display path: segment bit
// positions inside the 8-bit segment word and the all-off pattern.
package seg_display_pkg;

   // Bit order of a segment word is {dp,g,f,e,d,c,b,a}
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-low word with every segment (including dp) dark
   localparam logic [7:0] SEG_BLANK_N = 8'hFF;

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD to seven-segment decoder. The output is active-high in the order
// {g,f,e,d,c,b,a}; codes 10..15 decode to all segments off.
module seven_segment_decoder (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup of the lit segments for each BCD value
   always_comb begin
      seg = 7'h00;
      case (bcd)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for a common-anode multi-digit display.
// A writer loads a staging buffer through a valid/ready handshake; the
// staged frame is copied to the display registers only at a frame boundary
// so a frame is never shown half old, half new. Each digit slot starts with
// a blanking interval to suppress ghosting. Outputs are registered.
module seven_segment_scanner
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic                    lz_suppress,
   output logic [7:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_start
);

   localparam int SLOT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIG_W  = 4 * NUM_DIGITS;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0]     slot_cnt;
   logic [IDX_W-1:0]      digit_idx;
   logic                  slot_end;
   logic                  frame_end;

   logic [DIG_W-1:0]      disp_digits;
   logic [NUM_DIGITS-1:0] disp_dp;
   logic [DIG_W-1:0]      stg_digits;
   logic [NUM_DIGITS-1:0] stg_dp;
   logic                  pending;

   logic                  zero_run;
   logic [NUM_DIGITS-1:0] lz_mask;

   logic [3:0]            cur_digit;
   logic                  cur_dp;
   logic                  cur_supp;
   logic [6:0]            dec_seg;

   logic [7:0]            seg_n_p0;
   logic [NUM_DIGITS-1:0] an_n_p0;
   logic                  frame_start_p0;

   assign slot_end   = (slot_cnt == SLOT_LAST);
   assign frame_end  = slot_end && (digit_idx == IDX_LAST);
   assign load_ready = !pending;

   // Slot counter and digit index: the index steps once per completed slot
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else if (slot_end) begin
         slot_cnt  <= '0;
         digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
         slot_cnt  <= slot_cnt + 1'b1;
      end
   end

   // Double buffer: accept into staging when free, publish at frame boundary.
   // Accept needs !pending and publish needs pending, so they never collide;
   // data accepted on a boundary cycle waits for the next boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_digits  <= '0;
         stg_dp      <= '0;
         disp_digits <= '0;
         disp_dp     <= '0;
         pending     <= 1'b0;
      end else if (pending && frame_end) begin
         disp_digits <= stg_digits;
         disp_dp     <= stg_dp;
         pending     <= 1'b0;
      end else if (!pending && load_valid) begin
         stg_digits  <= digits_in;
         stg_dp      <= dp_in;
         pending     <= 1'b1;
      end
   end

   // Leading-zero mask: running AND of "is zero" from the MSB downward
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run && (disp_digits[4*i +: 4] == 4'd0);
         lz_mask[i] = lz_suppress && zero_run && (i != 0);
      end
   end

   // Select the digit, dp and suppression flag for the current slot
   always_comb begin
      cur_digit = disp_digits[3:0];
      cur_dp    = disp_dp[0];
      cur_supp  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            cur_digit = disp_digits[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_supp  = lz_mask[i];
         end
      end
   end

   seven_segment_decoder u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

   // Next output word: dark during blanking, otherwise one anode low
   always_comb begin
      seg_n_p0       = SEG_BLANK_N;
      an_n_p0        = '1;
      frame_start_p0 = (slot_cnt == '0) && (digit_idx == '0);
      if (slot_cnt >= SLOT_BLANK) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) an_n_p0[i] = 1'b0;
         end
         seg_n_p0[SEG_G:SEG_A] = cur_supp ? 7'h7F : ~dec_seg;
         seg_n_p0[SEG_DP]      = ~cur_dp;
      end
   end

   // ---- stage p0 -> output registers ----
   // Register the pin drivers so they change cleanly once per clock
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_n       <= SEG_BLANK_N;
         an_n        <= '1;
         frame_start <= 1'b0;
      end else begin
         seg_n       <= seg_n_p0;
         an_n        <= an_n_p0;
         frame_start <= frame_start_p0;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 8-cycle slots,
// 2 blank cycles). A reference model, working from the frame position and
// the frame contents, pushes the expected pins for every cycle; a monitor
// pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_seven_segment_scanner;

   localparam int N     = 4;
   localparam int R     = 8;
   localparam int B     = 2;
   localparam int FRAME = N * R;

   logic        clk         = 1'b0;
   logic        rst         = 1'b1;
   logic [15:0] digits_in   = '0;
   logic [3:0]  dp_in       = '0;
   logic        load_valid  = 1'b0;
   logic        lz_suppress = 1'b0;
   logic        load_ready;
   logic [7:0]  seg_n;
   logic [3:0]  an_n;
   logic        frame_start;

   seven_segment_scanner #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (R),
      .BLANK_CYCLES (B)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .lz_suppress (lz_suppress),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] an;
      logic       fs;
      logic       rdy;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   passed = 0;

   // Common-anode active-low codes for 0..9 with the dp dark
   logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   // Reference model state: position in the frame and the two frame buffers
   int          m_cnt  = 0;
   logic [15:0] m_disp = '0;
   logic [3:0]  m_dp   = '0;
   logic [15:0] m_stg  = '0;
   logic [3:0]  m_sdp  = '0;
   logic        m_pend = 1'b0;

   function automatic logic [7:0] exp_seg(input logic [15:0] d, input logic [3:0] dp,
                                          input int k, input logic lz);
      logic [15:0] hi;
      logic [7:0]  s;
      int          v;
      hi = d >> (4 * k);
      v  = int'(hi & 16'hF);
      // suppressed when this digit and everything above it are zero
      if (v > 9 || (lz && k > 0 && hi == 16'h0)) s = 8'hFF;
      else                                       s = seg_tbl[v];
      s[7] = ~dp[k];
      return s;
   endfunction

   initial begin
      exp_t e;
      int   slot, k;
      forever begin
         @(posedge clk);
         if (rst) begin
            e      = '{seg: 8'hFF, an: 4'hF, fs: 1'b0, rdy: 1'b1};
            m_cnt  = 0;
            m_disp = '0;
            m_dp   = '0;
            m_stg  = '0;
            m_sdp  = '0;
            m_pend = 1'b0;
         end else begin
            slot = m_cnt % R;
            k    = m_cnt / R;
            e.fs = (m_cnt == 0);
            if (slot < B) begin
               e.seg = 8'hFF;
               e.an  = 4'hF;
            end else begin
               e.seg = exp_seg(m_disp, m_dp, k, lz_suppress);
               e.an  = ~(4'b0001 << k);
            end
            if (m_pend && m_cnt == FRAME - 1) begin
               m_disp = m_stg;
               m_dp   = m_sdp;
               m_pend = 1'b0;
            end else if (!m_pend && load_valid) begin
               m_stg  = digits_in;
               m_sdp  = dp_in;
               m_pend = 1'b1;
            end
            m_cnt = (m_cnt + 1) % FRAME;
            e.rdy = !m_pend;
         end
         expq.push_back(e);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
   endtask

   // Monitor: every falling edge the DUT presents one output word
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("seg_n",       seg_n,                e.seg);
            chk("an_n",        {4'h0, an_n},         {4'h0, e.an});
            chk("frame_start", {7'h0, frame_start},  {7'h0, e.fs});
            chk("load_ready",  {7'h0, load_ready},   {7'h0, e.rdy});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer a frame and hold it until accepted; scramble the bus afterwards
   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      int waited;
      waited     = 0;
      digits_in  = d;
      dp_in      = p;
      load_valid = 1'b1;
      while (load_ready !== 1'b1 && waited < 3 * FRAME) begin
         tick(1);
         waited++;
      end
      if (load_ready !== 1'b1) begin
         checks++;
         $display("FAIL load_accept at %0t: got ready=%b required ready=1", $time, load_ready);
      end
      tick(1);
      load_valid = 1'b0;
      digits_in  = 16'($urandom);
      dp_in      = 4'($urandom);
   endtask

   task automatic wait_cnt(input int target);
      int waited;
      waited = 0;
      while (m_cnt != target && waited < 2 * FRAME) begin
         tick(1);
         waited++;
      end
      if (m_cnt != target) begin
         checks++;
         $display("FAIL wait_position at %0t: got %0d required %0d", $time, m_cnt, target);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog at %0t: got timeout required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(40);

      // single load, then two back-to-back loads
      do_load(16'h1234, 4'b0000);
      tick(70);
      do_load(16'h1111, 4'b0000);
      do_load(16'h2222, 4'b0000);
      tick(100);

      // leading-zero suppression
      lz_suppress = 1'b1;
      do_load(16'h0050, 4'b0000);
      tick(70);
      do_load(16'h0000, 4'b0000);
      tick(70);
      lz_suppress = 1'b0;

      // decimal point and invalid code
      do_load(16'h0000, 4'b0010);
      tick(70);
      do_load(16'h000A, 4'b0000);
      tick(70);

      // mid-slot reset with a frame still pending
      wait_cnt(1);
      do_load(16'h9876, 4'b1111);
      wait_cnt(2 * R + 5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(80);

      // randomized frames, gaps and suppression
      for (int it = 0; it < 25; it++) begin
         for (int j = 0; j < 4; j++)
            d[4*j +: 4] = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
         lz_suppress = 1'($urandom_range(1, 0));
         tick($urandom_range(40, 0));
         do_load(d, 4'($urandom));
      end
      tick(2 * FRAME);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
